// File: rtl/led_pattern_sequencer.sv
// Start/stop-controlled LED pattern engine: prescaled steps of ripple-left/right, bounce or fill.
// Optional LED_SEQ_ROUNDS_EN adds ROUNDS and a one-cycle `done` pulse after ROUNDS full periods.
module led_pattern_sequencer #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned TICK_DIV = 4
`ifdef LED_SEQ_ROUNDS_EN
  , parameter int unsigned ROUNDS = 2
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] led,
  output logic             busy,
  output logic             step_tick
`ifdef LED_SEQ_ROUNDS_EN
  , output logic           done
`endif
);

  localparam int unsigned   PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic {IDLE, RUN} state_t;
  typedef enum logic [1:0] {M_LEFT = 2'b00, M_RIGHT = 2'b01, M_BOUNCE = 2'b10, M_FILL = 2'b11} mode_t;

  state_t           state_q, state_d;
  mode_t            mode_q, mode_d;
  logic [WIDTH-1:0] led_q, led_d, led_step, led_start, led_home;
  logic [PW-1:0]    presc_q, presc_d;
  logic             dir_up_q, dir_up_d, dir_up_step;

`ifdef LED_SEQ_ROUNDS_EN
  localparam int unsigned PASS_W = (ROUNDS > 1) ? $clog2(ROUNDS + 1) : 1;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic              done_q, done_d;
`endif

  // Next pattern value for the latched mode
  always_comb begin
    led_step    = led_q;
    dir_up_step = dir_up_q;
    case (mode_q)
      M_LEFT:  led_step = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
      M_RIGHT: led_step = {led_q[0], led_q[WIDTH-1:1]};
      M_BOUNCE: begin
        if (dir_up_q) begin
          if (led_q[WIDTH-1]) begin
            led_step    = led_q >> 1;
            dir_up_step = 1'b0;
          end else begin
            led_step = led_q << 1;
          end
        end else begin
          if (led_q[0]) begin
            led_step    = led_q << 1;
            dir_up_step = 1'b1;
          end else begin
            led_step = led_q >> 1;
          end
        end
      end
      M_FILL:  led_step = (&led_q) ? '0 : {led_q[WIDTH-2:0], 1'b1};
      default: led_step = led_q;
    endcase
  end

  assign led_start = (mode == 2'b01) ? {1'b1, {(WIDTH-1){1'b0}}} : WIDTH'(1);
  assign led_home  = (mode_q == M_RIGHT) ? {1'b1, {(WIDTH-1){1'b0}}} : WIDTH'(1);
  assign step_tick = (state_q == RUN) && (presc_q == PRESC_MAX);

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    led_d    = led_q;
    presc_d  = presc_q;
    dir_up_d = dir_up_q;
`ifdef LED_SEQ_ROUNDS_EN
    pass_d   = pass_q;
    done_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d  = RUN;
          mode_d   = mode_t'(mode);
          led_d    = led_start;
          presc_d  = '0;
          dir_up_d = 1'b1;
`ifdef LED_SEQ_ROUNDS_EN
          pass_d   = '0;
`endif
        end
      end
      RUN: begin
        if (stop) begin
          state_d  = IDLE;
          led_d    = '0;
          presc_d  = '0;
          dir_up_d = 1'b1;
        end else if (step_tick) begin
          presc_d  = '0;
          led_d    = led_step;
          dir_up_d = dir_up_step;
`ifdef LED_SEQ_ROUNDS_EN
          // A pass ends on the step that brings the pattern back to its start value
          if (led_step == led_home) begin
            if (pass_q == PASS_W'(ROUNDS - 1)) begin
              state_d  = IDLE;
              led_d    = '0;
              dir_up_d = 1'b1;
              pass_d   = '0;
              done_d   = 1'b1;
            end else begin
              pass_d = pass_q + 1'b1;
            end
          end
`endif
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      mode_q   <= M_LEFT;
      led_q    <= '0;
      presc_q  <= '0;
      dir_up_q <= 1'b1;
`ifdef LED_SEQ_ROUNDS_EN
      pass_q   <= '0;
      done_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      led_q    <= led_d;
      presc_q  <= presc_d;
      dir_up_q <= dir_up_d;
`ifdef LED_SEQ_ROUNDS_EN
      pass_q   <= pass_d;
      done_q   <= done_d;
`endif
    end
  end

  assign led  = led_q;
  assign busy = (state_q == RUN);
`ifdef LED_SEQ_ROUNDS_EN
  assign done = done_q;
`endif

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench for led_pattern_sequencer (WIDTH=8, TICK_DIV=4); covers LED_SEQ_ROUNDS_EN when defined.
module tb_led_pattern_sequencer;

  localparam int TDIV = 4;
`ifdef LED_SEQ_ROUNDS_EN
  localparam int NROUNDS = 2;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0, start = 1'b0, stop = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] led;
  logic       busy, step_tick;
`ifdef LED_SEQ_ROUNDS_EN
  logic       done;
`endif

  always #5 clk = ~clk;

  led_pattern_sequencer #(
    .WIDTH(8),
    .TICK_DIV(TDIV)
`ifdef LED_SEQ_ROUNDS_EN
    , .ROUNDS(NROUNDS)
`endif
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode),
    .led(led), .busy(busy), .step_tick(step_tick)
`ifdef LED_SEQ_ROUNDS_EN
    , .done(done)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model: run flag plus cycles elapsed since the run began
  bit m_run  = 1'b0;
  int m_c    = 0;
  int m_mode = 0;
  bit m_done = 1'b0;

  function automatic int period(int md);
    case (md)
      0, 1:    return 8;
      2:       return 14;
      default: return 9;
    endcase
  endfunction

  function automatic logic [7:0] pat(int md, int k);
    int p;
    int one = 1;
    case (md)
      0: return 8'(one << (k % 8));
      1: return 8'(128 >> (k % 8));
      2: begin
        p = k % 14;
        return 8'(one << ((p < 8) ? p : 14 - p));
      end
      default: begin
        p = k % 9;
        return (p == 8) ? 8'h00 : 8'((one << (p + 1)) - 1);
      end
    endcase
  endfunction

  task automatic model_edge(input logic r, input logic s, input logic p, input logic [1:0] md);
    m_done = 1'b0;
    if (r) begin
      m_run = 1'b0;
      m_c   = 0;
    end else if (m_run) begin
      if (p) begin
        m_run = 1'b0;
        m_c   = 0;
      end else begin
        m_c++;
`ifdef LED_SEQ_ROUNDS_EN
        if (m_c == NROUNDS * period(m_mode) * TDIV) begin
          m_run  = 1'b0;
          m_c    = 0;
          m_done = 1'b1;
        end
`endif
      end
    end else if (s && !p) begin
      m_run  = 1'b1;
      m_c    = 0;
      m_mode = int'(md);
    end
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic p, input logic [1:0] md);
    reset = r; start = s; stop = p; mode = md;
    @(posedge clk);
    model_edge(r, s, p, md);
    #1;
    check("led", led, m_run ? pat(m_mode, m_c / TDIV) : 8'h00);
    check("busy", {7'b0, busy}, {7'b0, m_run});
    check("step_tick", {7'b0, step_tick}, {7'b0, (m_run && (m_c % TDIV == TDIV - 1))});
`ifdef LED_SEQ_ROUNDS_EN
    check("done", {7'b0, done}, {7'b0, m_done});
`endif
  endtask

  typedef struct {
    logic       r, s, p;
    logic [1:0] m;
    logic [7:0] led;
    logic       busy, tick;
  } vec_t;

  vec_t vecs[13];
  int   done_cnt;

  initial begin
    vecs[0]  = '{1, 0, 0, 2'b00, 8'h00, 0, 0};
    vecs[1]  = '{1, 0, 0, 2'b00, 8'h00, 0, 0};
    vecs[2]  = '{0, 0, 0, 2'b00, 8'h00, 0, 0};
    vecs[3]  = '{0, 1, 1, 2'b00, 8'h00, 0, 0};
    vecs[4]  = '{0, 1, 0, 2'b01, 8'h80, 1, 0};
    vecs[5]  = '{0, 1, 0, 2'b00, 8'h80, 1, 0};
    vecs[6]  = '{0, 0, 0, 2'b00, 8'h80, 1, 0};
    vecs[7]  = '{0, 0, 0, 2'b00, 8'h80, 1, 1};
    vecs[8]  = '{0, 0, 0, 2'b00, 8'h40, 1, 0};
    vecs[9]  = '{0, 0, 1, 2'b00, 8'h00, 0, 0};
    vecs[10] = '{0, 1, 0, 2'b11, 8'h01, 1, 0};
    vecs[11] = '{1, 1, 0, 2'b11, 8'h00, 0, 0};
    vecs[12] = '{0, 0, 0, 2'b11, 8'h00, 0, 0};

    for (int i = 0; i < 13; i++) begin
      cyc(vecs[i].r, vecs[i].s, vecs[i].p, vecs[i].m);
      check("vec_led", led, vecs[i].led);
      check("vec_busy", {7'b0, busy}, {7'b0, vecs[i].busy});
      check("vec_tick", {7'b0, step_tick}, {7'b0, vecs[i].tick});
    end

    // Reset then idle
    cyc(1, 0, 0, 2'b00);
    cyc(1, 0, 0, 2'b00);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 2'b00);

    // Ripple left through a full period and back to 0x01
    cyc(0, 1, 0, 2'b00);
    for (int i = 0; i < 40; i++) cyc(0, 0, 0, 2'b00);
    cyc(0, 0, 1, 2'b00);

    // Bounce past both ends
    cyc(0, 1, 0, 2'b10);
    for (int i = 0; i < 60; i++) cyc(0, 0, 0, 2'b10);
    cyc(0, 0, 1, 2'b10);

    // Fill with a mode change during the run
    cyc(0, 1, 0, 2'b11);
    for (int i = 0; i < 9; i++) cyc(0, 0, 0, 2'b11);
    for (int i = 0; i < 30; i++) cyc(0, 0, 0, 2'b00);
    cyc(0, 0, 1, 2'b00);

    // Stop mid-step at 0x08, then start/stop conflict, then start right
    cyc(0, 1, 0, 2'b00);
    for (int i = 0; i < 13; i++) cyc(0, 0, 0, 2'b00);
    check("mid_led", led, 8'h08);
    cyc(0, 0, 1, 2'b00);
    check("stop_led", led, 8'h00);
    check("stop_busy", {7'b0, busy}, 8'h00);
    cyc(0, 1, 1, 2'b00);
    check("conflict_busy", {7'b0, busy}, 8'h00);
    cyc(0, 1, 0, 2'b01);
    check("right_init", led, 8'h80);
    cyc(0, 0, 1, 2'b00);

`ifdef LED_SEQ_ROUNDS_EN
    // Two full ripple-left passes end the run with one done pulse
    done_cnt = 0;
    cyc(0, 1, 0, 2'b00);
    for (int i = 0; i < 70; i++) begin
      cyc(0, 0, 0, 2'b00);
      if (done === 1'b1) done_cnt++;
    end
    check("rounds_done_cnt", 8'(done_cnt), 8'd1);
    check("rounds_idle", {7'b0, busy}, 8'h00);
    check("rounds_led", led, 8'h00);
    // Early stop suppresses done
    done_cnt = 0;
    cyc(0, 1, 0, 2'b00);
    for (int i = 0; i < 39; i++) begin
      cyc(0, 0, 0, 2'b00);
      if (done === 1'b1) done_cnt++;
    end
    cyc(0, 0, 1, 2'b00);
    for (int i = 0; i < 30; i++) begin
      cyc(0, 0, 0, 2'b00);
      if (done === 1'b1) done_cnt++;
    end
    check("stop_no_done", 8'(done_cnt), 8'd0);
`endif

    // Random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 100) < 2, ($urandom % 100) < 8, ($urandom % 100) < 3, 2'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
